// File: rtl/branch_predictor_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_table_pkg
// Brief    : Shared constants for the branch prediction table: 2-bit counter
//            encodings and the conditional-branch opcode.
// Revision : 1.0 - initial release
// ============================================================================
package branch_predictor_table_pkg;

   // 2-bit saturating counter encodings (MSB is the taken prediction)
   localparam logic [1:0] BP_SNT = 2'b00;   // strongly not taken
   localparam logic [1:0] BP_WNT = 2'b01;   // weakly not taken
   localparam logic [1:0] BP_WT  = 2'b10;   // weakly taken
   localparam logic [1:0] BP_ST  = 2'b11;   // strongly taken

   // RISC-V conditional branch major opcode
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_table_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter2
// Brief    : Next-state logic of a 2-bit saturating taken/not-taken counter.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter2
   import branch_predictor_table_pkg::*;
(
   input  logic [1:0] state_i,
   input  logic       taken_i,
   output logic [1:0] state_o
);

   // Step toward BP_ST on taken, toward BP_SNT on not taken, holding at either end
   always_comb begin
      state_o = state_i;
      if (taken_i) begin
         if (state_i != BP_ST) begin
            state_o = state_i + 2'd1;
         end
      end else begin
         if (state_i != BP_SNT) begin
            state_o = state_i - 2'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_predictor_table.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_table
// Brief    : Table of 2-bit saturating counters predicting conditional
//            branches in IF (bimodal or gshare indexing), trained at EX
//            resolution, with saturating branch/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_table
   import branch_predictor_table_pkg::*;
#(
   parameter int         XLEN       = 32,
   parameter int         INDEX_BITS = 6,
   parameter int         GHR_BITS   = 0,
   parameter logic [1:0] INIT_STATE = 2'b01,
   parameter int         PERF_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [6:0]            IF_opcode,
   input  logic [XLEN-1:0]       IF_pc,
   input  logic [XLEN-1:0]       IF_imm,
   output logic                  branch_estimation,
   output logic [XLEN-1:0]       branch_target,
   output logic [INDEX_BITS-1:0] IF_pht_index,
   input  logic                  EX_branch,
   input  logic                  EX_branch_taken,
   input  logic                  EX_prediction,
   input  logic [INDEX_BITS-1:0] EX_pht_index,
   output logic [PERF_WIDTH-1:0] perf_branches,
   output logic [PERF_WIDTH-1:0] perf_mispredicts
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   if (GHR_BITS < 0 || GHR_BITS > INDEX_BITS) begin : g_ghr_check
      $error("branch_predictor_table: GHR_BITS must lie in 0..INDEX_BITS");
   end

   logic [1:0]            pht_q [ENTRIES];
   logic [1:0]            ctr_d;
   logic [1:0]            rd_ctr;
   logic [INDEX_BITS-1:0] hist;
   logic [PERF_WIDTH-1:0] branches_q,    branches_d;
   logic [PERF_WIDTH-1:0] mispredicts_q, mispredicts_d;

   // ---------------------------------------------------------------------
   // Global history: only resolved branches shift in, nothing speculative
   // ---------------------------------------------------------------------
   if (GHR_BITS > 0) begin : g_gshare
      logic [GHR_BITS-1:0] ghr_q, ghr_d;
      logic [GHR_BITS:0]   ghr_shift;

      // Shift the resolved direction into the LSB, dropping the oldest bit
      always_comb begin
         ghr_shift = {ghr_q, EX_branch_taken};
         ghr_d     = ghr_shift[GHR_BITS-1:0];
      end

      // History register, advanced once per resolved branch
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            ghr_q <= '0;
         end else if (EX_branch) begin
            ghr_q <= ghr_d;
         end
      end

      assign hist = INDEX_BITS'(ghr_q);
   end else begin : g_bimodal
      assign hist = '0;
   end

   assign IF_pht_index = IF_pc[INDEX_BITS+1:2] ^ hist;
   assign rd_ctr       = pht_q[IF_pht_index];

   // Combinational prediction; only conditional branches may predict taken
   always_comb begin
      branch_estimation = 1'b0;
      branch_target     = IF_pc + XLEN'(4);
      if (IF_opcode == OPCODE_BRANCH) begin
         branch_estimation = rd_ctr[1];
         if (rd_ctr[1]) begin
            branch_target = IF_pc + IF_imm;
         end
      end
   end

   // Single counter update on the EX write path
   sat_counter2 u_sat_counter2 (
      .state_i (pht_q[EX_pht_index]),
      .taken_i (EX_branch_taken),
      .state_o (ctr_d)
   );

   // Counter table; the IF read above sees the value before this edge's write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            pht_q[i] <= INIT_STATE;
         end
      end else if (EX_branch) begin
         pht_q[EX_pht_index] <= ctr_d;
      end
   end

   // Saturating performance counter next-state
   always_comb begin
      branches_d    = branches_q;
      mispredicts_d = mispredicts_q;
      if (EX_branch) begin
         if (branches_q != '1) begin
            branches_d = branches_q + PERF_WIDTH'(1);
         end
         if ((EX_prediction != EX_branch_taken) && (mispredicts_q != '1)) begin
            mispredicts_d = mispredicts_q + PERF_WIDTH'(1);
         end
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         branches_q    <= '0;
         mispredicts_q <= '0;
      end else begin
         branches_q    <= branches_d;
         mispredicts_q <= mispredicts_d;
      end
   end

   assign perf_branches    = branches_q;
   assign perf_mispredicts = mispredicts_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_table
// Brief    : Scoreboard bench for branch_predictor_table: three instances
//            (bimodal, gshare GHR_BITS=4, 4-bit perf counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_table;

   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_ALU = 7'b0110011;

   typedef struct {
      int          id;
      string       tag;
      logic        est;
      logic [31:0] tgt;
      logic [5:0]  idx;
      logic [31:0] pb;
      logic [31:0] pm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [6:0]  opc   [3];
   logic [31:0] pc    [3];
   logic [31:0] imm   [3];
   logic        ex_b  [3];
   logic        ex_t  [3];
   logic        ex_p  [3];
   logic [5:0]  ex_i  [3];

   logic        a_est, b_est, c_est;
   logic [31:0] a_tgt, b_tgt, c_tgt;
   logic [5:0]  a_idx, b_idx, c_idx;
   logic [31:0] a_pb, a_pm, b_pb, b_pm;
   logic [3:0]  c_pb, c_pm;

   always #5 clk = ~clk;

   branch_predictor_table #(.GHR_BITS(0), .PERF_WIDTH(32)) u_bim (
      .clk(clk), .reset_n(reset_n), .IF_opcode(opc[0]), .IF_pc(pc[0]), .IF_imm(imm[0]),
      .branch_estimation(a_est), .branch_target(a_tgt), .IF_pht_index(a_idx),
      .EX_branch(ex_b[0]), .EX_branch_taken(ex_t[0]), .EX_prediction(ex_p[0]),
      .EX_pht_index(ex_i[0]), .perf_branches(a_pb), .perf_mispredicts(a_pm));

   branch_predictor_table #(.GHR_BITS(4), .PERF_WIDTH(32)) u_gsh (
      .clk(clk), .reset_n(reset_n), .IF_opcode(opc[1]), .IF_pc(pc[1]), .IF_imm(imm[1]),
      .branch_estimation(b_est), .branch_target(b_tgt), .IF_pht_index(b_idx),
      .EX_branch(ex_b[1]), .EX_branch_taken(ex_t[1]), .EX_prediction(ex_p[1]),
      .EX_pht_index(ex_i[1]), .perf_branches(b_pb), .perf_mispredicts(b_pm));

   branch_predictor_table #(.GHR_BITS(0), .PERF_WIDTH(4)) u_prf (
      .clk(clk), .reset_n(reset_n), .IF_opcode(opc[2]), .IF_pc(pc[2]), .IF_imm(imm[2]),
      .branch_estimation(c_est), .branch_target(c_tgt), .IF_pht_index(c_idx),
      .EX_branch(ex_b[2]), .EX_branch_taken(ex_t[2]), .EX_prediction(ex_p[2]),
      .EX_pht_index(ex_i[2]), .perf_branches(c_pb), .perf_mispredicts(c_pm));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: pop every expectation queued for this cycle and compare
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t        e;
         logic        est;
         logic [31:0] tgt, pb, pm;
         logic [5:0]  idx;
         e = sb.pop_front();
         case (e.id)
            0:       begin est = a_est; tgt = a_tgt; idx = a_idx; pb = a_pb; pm = a_pm; end
            1:       begin est = b_est; tgt = b_tgt; idx = b_idx; pb = b_pb; pm = b_pm; end
            default: begin est = c_est; tgt = c_tgt; idx = c_idx; pb = {28'd0, c_pb}; pm = {28'd0, c_pm}; end
         endcase
         chk({e.tag, " est"}, {31'd0, est}, {31'd0, e.est});
         chk({e.tag, " tgt"}, tgt, e.tgt);
         chk({e.tag, " idx"}, {26'd0, idx}, {26'd0, e.idx});
         chk({e.tag, " perf_br"}, pb, e.pb);
         chk({e.tag, " perf_mp"}, pm, e.pm);
      end
   end

   // One cycle of stimulus on instance id plus its expected response
   task automatic step(input int id, input string tag,
                       input logic [6:0] o, input logic [31:0] p, input logic [31:0] im,
                       input logic eb, input logic et, input logic ep, input logic [5:0] ei,
                       input logic x_est, input logic [31:0] x_tgt, input logic [5:0] x_idx,
                       input logic [31:0] x_pb, input logic [31:0] x_pm);
      exp_t e;
      for (int k = 0; k < 3; k++) ex_b[k] = 1'b0;
      opc[id] = o; pc[id] = p; imm[id] = im;
      ex_b[id] = eb; ex_t[id] = et; ex_p[id] = ep; ex_i[id] = ei;
      e.id = id; e.tag = tag; e.est = x_est; e.tgt = x_tgt; e.idx = x_idx;
      e.pb = x_pb; e.pm = x_pm;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         opc[k] = OP_ALU; pc[k] = 32'h0; imm[k] = 32'h0;
         ex_b[k] = 1'b0; ex_t[k] = 1'b0; ex_p[k] = 1'b0; ex_i[k] = 6'h0;
      end
      @(posedge clk);
      #1;
      // reset held from time zero
      step(0, "rst_hold", OP_BR, 32'h100, 32'h40, 0,0,0,6'h00, 0, 32'h104, 6'h00, 0, 0);
      reset_n = 1'b1;
      // some training before a mid-run reset
      step(0, "pre_t1",   OP_BR, 32'h100, 32'h40, 1,1,0,6'h00, 0, 32'h104, 6'h00, 0, 0);
      step(0, "pre_t2",   OP_BR, 32'h100, 32'h40, 1,1,1,6'h00, 1, 32'h140, 6'h00, 1, 1);
      reset_n = 1'b0;
      step(0, "rst_mid",  OP_BR, 32'h100, 32'h40, 1,1,0,6'h00, 0, 32'h104, 6'h00, 0, 0);
      reset_n = 1'b1;
      step(0, "post_rst", OP_BR, 32'h100, 32'h40, 0,0,0,6'h00, 0, 32'h104, 6'h00, 0, 0);
      // bimodal training at index 0
      step(0, "tr1",      OP_BR, 32'h100, 32'h40, 1,1,0,6'h00, 0, 32'h104, 6'h00, 0, 0);
      step(0, "tr2",      OP_BR, 32'h100, 32'h40, 1,1,1,6'h00, 1, 32'h140, 6'h00, 1, 1);
      step(0, "tr_pc100", OP_BR, 32'h100, 32'h40, 0,0,0,6'h00, 1, 32'h140, 6'h00, 2, 1);
      step(0, "alias200", OP_BR, 32'h200, 32'h40, 0,0,0,6'h00, 1, 32'h240, 6'h00, 2, 1);
      step(0, "idx1",     OP_BR, 32'h104, 32'h40, 0,0,0,6'h00, 0, 32'h108, 6'h01, 2, 1);
      step(0, "nonbr",    OP_ALU,32'h100, 32'h40, 0,0,0,6'h00, 0, 32'h104, 6'h00, 2, 1);
      // saturation: 4 not taken, then 4 taken
      step(0, "nt1",      OP_BR, 32'h100, 32'h40, 1,0,1,6'h00, 1, 32'h140, 6'h00, 2, 1);
      step(0, "nt2",      OP_BR, 32'h100, 32'h40, 1,0,1,6'h00, 1, 32'h140, 6'h00, 3, 2);
      step(0, "nt3",      OP_BR, 32'h100, 32'h40, 1,0,0,6'h00, 0, 32'h104, 6'h00, 4, 3);
      step(0, "nt4",      OP_BR, 32'h100, 32'h40, 1,0,0,6'h00, 0, 32'h104, 6'h00, 5, 3);
      step(0, "t1",       OP_BR, 32'h100, 32'h40, 1,1,0,6'h00, 0, 32'h104, 6'h00, 6, 3);
      step(0, "t2",       OP_BR, 32'h100, 32'h40, 1,1,0,6'h00, 0, 32'h104, 6'h00, 7, 4);
      step(0, "t3",       OP_BR, 32'h100, 32'h40, 1,1,1,6'h00, 1, 32'h140, 6'h00, 8, 5);
      step(0, "t4",       OP_BR, 32'h100, 32'h40, 1,1,1,6'h00, 1, 32'h140, 6'h00, 9, 5);
      step(0, "sat_hi",   OP_BR, 32'h100, 32'h40, 0,0,0,6'h00, 1, 32'h140, 6'h00, 10, 5);
      // same-cycle read/write of index 5
      step(0, "haz_same", OP_BR, 32'h14,  32'h40, 1,1,0,6'h05, 0, 32'h18,  6'h05, 10, 5);
      step(0, "haz_next", OP_BR, 32'h14,  32'h40, 0,0,0,6'h00, 1, 32'h54,  6'h05, 11, 6);
      // address wrap
      step(0, "wrap_imm", OP_BR, 32'hFFFF_FF14, 32'h100, 0,0,0,6'h00, 1, 32'h14, 6'h05, 11, 6);
      step(0, "wrap_p4",  OP_ALU,32'hFFFF_FFFC, 32'h100, 0,0,0,6'h00, 0, 32'h0,  6'h3F, 11, 6);

      // gshare: resolve T,T,N,T at index 0x20
      step(1, "g_h0",     OP_BR, 32'h100, 32'h40, 1,1,1,6'h20, 0, 32'h104, 6'h00, 0, 0);
      step(1, "g_h1",     OP_BR, 32'h100, 32'h40, 1,1,1,6'h20, 0, 32'h104, 6'h01, 1, 0);
      step(1, "g_h3",     OP_BR, 32'h100, 32'h40, 1,0,0,6'h20, 0, 32'h104, 6'h03, 2, 0);
      step(1, "g_h6",     OP_BR, 32'h100, 32'h40, 1,1,1,6'h20, 0, 32'h104, 6'h06, 3, 0);
      step(1, "g_hD",     OP_BR, 32'h100, 32'h40, 1,1,0,6'h0D, 0, 32'h104, 6'h0D, 4, 0);
      // GHR now 4'b1011
      step(1, "g_idx0",   OP_BR, 32'h2C,  32'h40, 0,0,0,6'h00, 0, 32'h30,  6'h00, 5, 1);
      step(1, "g_idxD",   OP_BR, 32'h18,  32'h40, 0,0,0,6'h00, 1, 32'h58,  6'h0D, 5, 1);
      step(1, "g_idx20",  OP_BR, 32'hAC,  32'h40, 0,0,0,6'h00, 1, 32'hEC,  6'h20, 5, 1);

      // 4-bit perf counters: 5 branches, 2 mismatches, interleaved non-branches
      step(2, "p1", OP_BR,  32'h300, 32'h40, 1,1,1,6'h10, 0, 32'h304, 6'h00, 0, 0);
      step(2, "p2", OP_ALU, 32'h300, 32'h40, 0,0,0,6'h10, 0, 32'h304, 6'h00, 1, 0);
      step(2, "p3", OP_ALU, 32'h300, 32'h40, 1,1,0,6'h10, 0, 32'h304, 6'h00, 1, 0);
      step(2, "p4", OP_BR,  32'h300, 32'h40, 1,0,0,6'h10, 0, 32'h304, 6'h00, 2, 1);
      step(2, "p5", OP_ALU, 32'h300, 32'h40, 0,0,0,6'h10, 0, 32'h304, 6'h00, 3, 1);
      step(2, "p6", OP_BR,  32'h300, 32'h40, 1,0,1,6'h10, 0, 32'h304, 6'h00, 3, 1);
      step(2, "p7", OP_ALU, 32'h300, 32'h40, 1,1,1,6'h10, 0, 32'h304, 6'h00, 4, 2);
      step(2, "p8", OP_BR,  32'h300, 32'h40, 0,0,0,6'h10, 0, 32'h304, 6'h00, 5, 2);
      for (int i = 0; i < 20; i++) begin
         step(2, "p_corr", OP_BR, 32'h300, 32'h40, 1,1,1,6'h10, 0, 32'h304, 6'h00,
              (5 + i > 15) ? 32'd15 : 32'(5 + i), 2);
      end
      step(2, "p_brsat", OP_BR, 32'h300, 32'h40, 0,0,0,6'h10, 0, 32'h304, 6'h00, 15, 2);
      for (int i = 0; i < 16; i++) begin
         step(2, "p_mis", OP_BR, 32'h300, 32'h40, 1,0,1,6'h10, 0, 32'h304, 6'h00,
              15, (2 + i > 15) ? 32'd15 : 32'(2 + i));
      end
      step(2, "p_mpsat", OP_BR, 32'h300, 32'h40, 0,0,0,6'h10, 0, 32'h304, 6'h00, 15, 15);

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
